// File: rtl/i2c_bus_frontend.sv
// i2c_bus_frontend: synchronizes and deglitches SCL/SDA, detects START/STOP and SCL edges,
// and tracks bit count, received byte and address match for the I2C subordinate.
module i2c_bus_frontend #(
   parameter logic [6:0] ADDR = 7'h42,
   parameter int FILTER_LEN = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   input  logic       read_ack,
   output logic       scl_filt,
   output logic       sda_filt,
   output logic       scl_rise,
   output logic       scl_fall,
   output logic       start_cond,
   output logic       stop_cond,
   output logic [3:0] clock_count,
   output logic       address_match,
   output logic       read_bit,
   output logic       write_bit,
   output logic       received_nack,
   output logic [7:0] rx_byte,
   output logic       rx_valid
);
   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
   localparam logic [3:0] FL_MAX = 4'(FILTER_LEN - 1);
   logic [1:0] scl_sync, sda_sync;
   logic [3:0] scl_cnt, sda_cnt;
   logic scl_d, sda_d;
   logic [7:0] shreg, sh_nx;
   logic d_rise, d_fall, d_start, d_stop;
   state_t state, state_nx;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_filt <= 1'b1;
         sda_filt <= 1'b1;
         scl_cnt <= '0;
         sda_cnt <= '0;
         scl_d <= 1'b1;
         sda_d <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl_in};
         sda_sync <= {sda_sync[0], sda_in};
         scl_d <= scl_filt;
         sda_d <= sda_filt;
         if (scl_sync[1] == scl_filt) scl_cnt <= '0;
         else if (scl_cnt == FL_MAX) begin
            scl_filt <= scl_sync[1];
            scl_cnt <= '0;
         end else scl_cnt <= scl_cnt + 4'd1;
         if (sda_sync[1] == sda_filt) sda_cnt <= '0;
         else if (sda_cnt == FL_MAX) begin
            sda_filt <= sda_sync[1];
            sda_cnt <= '0;
         end else sda_cnt <= sda_cnt + 4'd1;
      end
   // Events are derived from the filtered lines one cycle late, so an SCL change masks START/STOP.
   always_comb begin
      d_rise = scl_filt & ~scl_d;
      d_fall = ~scl_filt & scl_d;
      d_start = scl_filt & scl_d & sda_d & ~sda_filt;
      d_stop = scl_filt & scl_d & ~sda_d & sda_filt;
      sh_nx = {shreg[6:0], sda_filt};
      state_nx = d_start ? S_ADDR :
                 d_stop ? S_IDLE :
                 (d_rise && state == S_ADDR && clock_count == 4'd8) ? S_DATA : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         scl_rise <= 1'b0;
         scl_fall <= 1'b0;
         start_cond <= 1'b0;
         stop_cond <= 1'b0;
         clock_count <= '0;
         address_match <= 1'b0;
         read_bit <= 1'b0;
         write_bit <= 1'b0;
         received_nack <= 1'b0;
         shreg <= '0;
         rx_byte <= '0;
         rx_valid <= 1'b0;
      end else begin
         scl_rise <= d_rise;
         scl_fall <= d_fall;
         start_cond <= d_start;
         stop_cond <= d_stop;
         rx_valid <= 1'b0;
         if (d_start || d_stop) begin
            clock_count <= '0;
            address_match <= 1'b0;
            read_bit <= 1'b0;
            write_bit <= 1'b0;
            received_nack <= 1'b0;
         end else if (d_rise && state != S_IDLE) begin
            if (clock_count == 4'd8) begin
               clock_count <= '0;
               if (read_ack && sda_filt) received_nack <= 1'b1;
            end else begin
               shreg <= sh_nx;
               clock_count <= clock_count + 4'd1;
               if (clock_count == 4'd7) begin
                  rx_byte <= sh_nx;
                  rx_valid <= 1'b1;
                  if (state == S_ADDR) begin
                     address_match <= sh_nx[7:1] == ADDR;
                     read_bit <= sh_nx[0];
                     write_bit <= ~sh_nx[0];
                  end
               end
            end
         end
      end
endmodule

// File: tb/tb_i2c_bus_frontend.sv
// tb_i2c_bus_frontend: directed I2C pin waveforms checked each cycle against a
// behavioural pin-to-event model, plus literal expectations at key protocol points.
module tb_i2c_bus_frontend;
   localparam int FL = 3;
   localparam int H = 8;
   logic clk = 1'b0, rst_n = 1'b0, scl_in = 1'b1, sda_in = 1'b1, read_ack = 1'b0;
   logic scl_filt, sda_filt, scl_rise, scl_fall, start_cond, stop_cond;
   logic [3:0] clock_count;
   logic address_match, read_bit, write_bit, received_nack, rx_valid;
   logic [7:0] rx_byte;
   i2c_bus_frontend #(.ADDR(7'h42), .FILTER_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in), .read_ack(read_ack),
      .scl_filt(scl_filt), .sda_filt(sda_filt), .scl_rise(scl_rise), .scl_fall(scl_fall),
      .start_cond(start_cond), .stop_cond(stop_cond), .clock_count(clock_count),
      .address_match(address_match), .read_bit(read_bit), .write_bit(write_bit),
      .received_nack(received_nack), .rx_byte(rx_byte), .rx_valid(rx_valid)
   );
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0;
   int n_start = 0, n_stop = 0, n_rise = 0, n_fall = 0, n_valid = 0, last_rx = -1;
   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Model: pins pass a 2-deep delay, a line flips once the last FL delayed samples all
   // disagree with it, and events appear one edge after the flip.
   bit ps_scl[2], ps_sda[2], h_scl[16], h_sda[16];
   bit m_scl, m_sda, c_scl, c_sda, ev_r, ev_f, ev_s, ev_p, s2_scl, s2_sda, all_scl, all_sda;
   bit m_rise, m_fall, m_start, m_stop, m_valid, m_match, m_rd, m_wr, m_nack;
   int m_mode, m_count, m_acc, m_rx;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_scl = '{1, 1};
         ps_sda = '{1, 1};
         for (int i = 0; i < 16; i++) begin
            h_scl[i] = 1;
            h_sda[i] = 1;
         end
         m_scl = 1; m_sda = 1; c_scl = 0; c_sda = 0;
         m_rise = 0; m_fall = 0; m_start = 0; m_stop = 0; m_valid = 0;
         m_match = 0; m_rd = 0; m_wr = 0; m_nack = 0;
         m_mode = 0; m_count = 0; m_acc = 0; m_rx = 0;
      end else begin
         ev_r = c_scl & m_scl;
         ev_f = c_scl & ~m_scl;
         ev_s = c_sda & ~m_sda & ~c_scl & m_scl;
         ev_p = c_sda & m_sda & ~c_scl & m_scl;
         m_rise = ev_r; m_fall = ev_f; m_start = ev_s; m_stop = ev_p; m_valid = 0;
         if (ev_s || ev_p) begin
            m_mode = ev_s ? 1 : 0;
            m_count = 0; m_match = 0; m_rd = 0; m_wr = 0; m_nack = 0;
         end else if (ev_r && m_mode != 0) begin
            if (m_count == 8) begin
               m_count = 0;
               if (read_ack && m_sda) m_nack = 1;
               if (m_mode == 1) m_mode = 2;
            end else begin
               m_acc = (m_acc * 2 + int'(m_sda)) % 256;
               m_count++;
               if (m_count == 8) begin
                  m_rx = m_acc;
                  m_valid = 1;
                  if (m_mode == 1) begin
                     m_match = (m_acc / 2) == 'h42;
                     m_rd = (m_acc % 2) == 1;
                     m_wr = (m_acc % 2) == 0;
                  end
               end
            end
         end
         s2_scl = ps_scl[1]; ps_scl[1] = ps_scl[0]; ps_scl[0] = scl_in;
         s2_sda = ps_sda[1]; ps_sda[1] = ps_sda[0]; ps_sda[0] = sda_in;
         for (int i = 15; i > 0; i--) begin
            h_scl[i] = h_scl[i-1];
            h_sda[i] = h_sda[i-1];
         end
         h_scl[0] = s2_scl;
         h_sda[0] = s2_sda;
         all_scl = 1; all_sda = 1;
         for (int i = 0; i < FL; i++) begin
            if (h_scl[i] == m_scl) all_scl = 0;
            if (h_sda[i] == m_sda) all_sda = 0;
         end
         c_scl = all_scl; c_sda = all_sda;
         if (all_scl) m_scl = ~m_scl;
         if (all_sda) m_sda = ~m_sda;
      end
   end
   always @(posedge clk) begin
      #1;
      check("scl_filt", scl_filt, m_scl);
      check("sda_filt", sda_filt, m_sda);
      check("scl_rise", scl_rise, m_rise);
      check("scl_fall", scl_fall, m_fall);
      check("start_cond", start_cond, m_start);
      check("stop_cond", stop_cond, m_stop);
      check("clock_count", clock_count, m_count);
      check("address_match", address_match, m_match);
      check("read_bit", read_bit, m_rd);
      check("write_bit", write_bit, m_wr);
      check("received_nack", received_nack, m_nack);
      check("rx_byte", rx_byte, m_rx);
      check("rx_valid", rx_valid, m_valid);
      if (start_cond) n_start++;
      if (stop_cond) n_stop++;
      if (scl_rise) n_rise++;
      if (scl_fall) n_fall++;
      if (rx_valid) begin
         n_valid++;
         last_rx = rx_byte;
      end
   end
   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic pins(input logic c, input logic d);
      scl_in = c;
      sda_in = d;
      hold(H);
   endtask
   task automatic start_c;
      pins(scl_in, 1'b1);
      pins(1'b1, 1'b1);
      pins(1'b1, 1'b0);
      pins(1'b0, 1'b0);
   endtask
   task automatic stop_c;
      pins(1'b0, 1'b0);
      pins(1'b1, 1'b0);
      pins(1'b1, 1'b1);
   endtask
   task automatic send_bit(input logic b);
      pins(1'b0, b);
      pins(1'b1, b);
      pins(1'b0, b);
   endtask
   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: run did not complete within time limit");
      $fatal(1, "watchdog");
   end
   int s0, p0, r0, f0;
   initial begin
      hold(3);
      check("lit_reset_scl", scl_filt, 1);
      check("lit_reset_count", clock_count, 0);
      check("lit_reset_rx", rx_byte, 0);
      rst_n = 1'b1;
      hold(H);
      s0 = n_start;
      start_c;
      check("lit_start_once", n_start - s0, 1);
      send_bits(8'h84, 8);
      check("lit_wr_count8", clock_count, 8);
      check("lit_wr_rx", last_rx, 'h84);
      check("lit_wr_match", address_match, 1);
      check("lit_wr_write", write_bit, 1);
      check("lit_wr_read", read_bit, 0);
      send_bit(1'b0);
      check("lit_wr_count0", clock_count, 0);
      send_bits(8'h00, 5);
      check("lit_mid_count5", clock_count, 5);
      rst_n = 1'b0;
      scl_in = 1'b1;
      sda_in = 1'b1;
      hold(3);
      rst_n = 1'b1;
      hold(H);
      check("lit_rst_count", clock_count, 0);
      check("lit_rst_rx", rx_byte, 0);
      check("lit_rst_match", address_match, 0);
      check("lit_rst_sda", sda_filt, 1);
      start_c;
      check("lit_restart_count", clock_count, 0);
      send_bits(8'h91, 8);
      check("lit_bad_match", address_match, 0);
      check("lit_bad_read", read_bit, 1);
      check("lit_bad_rx", last_rx, 'h91);
      send_bit(1'b0);
      send_bits(8'hA5, 8);
      check("lit_data_rx", last_rx, 'hA5);
      read_ack = 1'b1;
      send_bit(1'b0);
      read_ack = 1'b0;
      check("lit_ack_nonack", received_nack, 0);
      send_bits(8'h3C, 8);
      read_ack = 1'b1;
      send_bit(1'b1);
      read_ack = 1'b0;
      check("lit_nack_set", received_nack, 1);
      start_c;
      check("lit_rs_nack_clr", received_nack, 0);
      check("lit_rs_count", clock_count, 0);
      send_bits(8'hE0, 3);
      check("lit_stop_pre", clock_count, 3);
      p0 = n_stop;
      stop_c;
      check("lit_stop_seen", n_stop - p0, 1);
      check("lit_stop_count", clock_count, 0);
      send_bits(8'hFF, 3);
      check("lit_idle_count", clock_count, 0);
      pins(1'b1, 1'b1);
      s0 = n_start;
      sda_in = 1'b0;
      hold(2);
      sda_in = 1'b1;
      hold(H);
      check("lit_glitch2", n_start - s0, 0);
      sda_in = 1'b0;
      hold(3);
      sda_in = 1'b1;
      hold(H);
      check("lit_glitch3", n_start - s0, 1);
      s0 = n_start; p0 = n_stop; r0 = n_rise; f0 = n_fall;
      pins(1'b0, 1'b0);
      pins(1'b1, 1'b1);
      check("lit_simul_start", n_start - s0, 0);
      check("lit_simul_stop", n_stop - p0, 0);
      check("lit_simul_fall", n_fall - f0, 1);
      check("lit_simul_rise", n_rise - r0, 1);
      hold(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/i2c_bus_frontend.md
# i2c_bus_frontend

Oversampling front end for the I2C subordinate interface, clocked by the system clock. Synchronizes and deglitches the raw SCL/SDA pins, detects START/STOP conditions and SCL edges, and runs the bit counter, receive shift register and address comparator. It feeds the subordinate state machine with `start_cond`, `stop_cond`, `clock_count`, `address_match`, `read_bit`, `write_bit` and `received_nack`.

## Interface
- `ADDR`, default 7'h42: 7-bit subordinate address.
- `FILTER_LEN`, default 3: number of consecutive identical synchronized samples required to accept a line change. Legal range 1..15.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `scl_in`  in  1  raw SCL pin.
- `sda_in`  in  1  raw SDA pin.
- `read_ack`  in  1  level from the state machine; high during the master-ACK slot of a subordinate-to-master transfer.
- `scl_filt`, `sda_filt`  out  1 each  deglitched line values.
- `scl_rise`, `scl_fall`  out  1 each  one-`clk` pulses on filtered SCL edges.
- `start_cond`, `stop_cond`  out  1 each  one-`clk` pulses.
- `clock_count`  out  4  index of the next bit to sample, 0..8.
- `address_match`, `read_bit`, `write_bit`  out  1 each  address-phase results.
- `received_nack`  out  1  sticky; the master NACKed.
- `rx_byte`  out  8  last completed byte, MSB first.
- `rx_valid`  out  1  one-`clk` pulse when `rx_byte` updates.

## Operation
- **Synchronizer:** 2 flops per line, reset value 1.
- **Filter:** per-line counter. The filtered value takes the synchronized value only after FILTER_LEN consecutive `clk` samples that differ from the current filtered value. Any mismatching sample resets the counter.
- **Edges:** `scl_rise`/`scl_fall` pulse in the cycle after the filtered SCL changes.
- **START:** `sda_filt` falls while `scl_filt` is high and SCL is unchanged in the same cycle.
- **STOP:** `sda_filt` rises while `scl_filt` is high and SCL is unchanged in the same cycle.
- **Simultaneous change:** if SCL and SDA change in the same cycle, there is no START/STOP; only the SCL edge is processed.
- **Byte FSM states:**
  - IDLE: until the first START after reset, or after a STOP.
  - ADDR: bits 0..8 of the first byte.
  - DATA: subsequent bytes.
- **Transitions:**
  - START (including a repeated START) in any state: go to ADDR, set `clock_count`=0, clear `address_match`/`read_bit`/`write_bit`/`received_nack`.
  - STOP in any state: go to IDLE with the same clears.
  - ADDR: after the ack slot (the rise at count 8), go to DATA.
- **On `scl_rise` in ADDR/DATA:**
  - count 0..7: shift `sda_filt` into the shift register LSB and increment the count.
  - count 7 (the 8th bit): also set `rx_byte` to the full shift register and pulse `rx_valid` the same cycle.
  - count 8: ack slot, count wraps to 0.
- **Address decode, in ADDR on completion of the 8th bit:**
  - `address_match` = (byte[7:1]==ADDR).
  - `read_bit` = byte[0]; `write_bit` = ~byte[0].
  - These hold until the next START or STOP.
- **Master NACK:** at an ack-slot rise with `read_ack`=1 and `sda_filt`=1, set `received_nack`=1. It is sticky until START, STOP or reset.
- **Ignored SCL rises:** `scl_rise` in IDLE does nothing.

## Timing
- Reset values:
  - `scl_filt`=`sda_filt`=1.
  - All pulses 0, `clock_count`=0, flags 0, `rx_byte`=8'h00.
  - FSM in IDLE, filter counters 0.
- Reset is asynchronous; asserting it mid-byte discards the partial byte.
- Pin change to filtered change: 2 + FILTER_LEN `clk` cycles. Filtered change to pulse: 1 `clk` cycle.
- `clock_count`, `rx_byte`, `rx_valid`, the address flags and `received_nack` all update in the same cycle as the causing `scl_rise` pulse.
- START/STOP take priority over an SCL edge in the same cycle; they cannot coincide by construction.
- Minimum SCL high/low time for correct operation: FILTER_LEN + 3 `clk` cycles.

## Test plan
- **Reset:** assert `rst_n`=0 mid-byte (count 5), then release → all outputs at reset values; next START gives count 0.
- **Write address:** START, address 0x84 (7'h42 + W) → `address_match`=1, `write_bit`=1, `rx_byte`=8'h84 with `rx_valid` on the 8th rise, `clock_count` 8 then 0 after the ack rise.
- **Wrong address:** address 0x91 (7'h48 + R) → `address_match`=0, `read_bit`=1; data byte 0xA5 → `rx_byte`=8'hA5.
- **Glitch rejection:** FILTER_LEN=3, 2-cycle SDA low pulse while SCL high → no `start_cond`; 3-cycle pulse → `start_cond` once.
- **Master NACK:** `read_ack`=1, SDA high at the ack rise → `received_nack`=1. A repeated START then clears it, and `clock_count`=0.
- **Simultaneous change:** SCL and SDA change in the same cycle → only `scl_rise`/`scl_fall`, no START/STOP. STOP mid-byte → IDLE, and further SCL rises leave count 0.
